seg_scan_display: RTL

// - Parametrised multiplexed seven-segment display controller: selects one of NUM_SRC 32-bit sources and shows it as hex or decimal on DIGITS digits.
// - Decimal conversion is a sequential double-dabble engine (one bit per clk), not a combinational converter.
// - Display is frame-synchronous with a hold (freeze) input and an overflow flag.
// - Sits between CPU statistics/memory outputs and the board SEG/AN pins.

---
 rtl/seg_scan_display_if.sv | 27 ++
 rtl/seg_scan_display.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display_if.sv
// Bus bundle for seg_scan_display: source selection/data in, segment/anode pins and status out.
// Parameters must match the seg_scan_display instance they connect to.
interface seg_scan_display_if #(
    parameter int unsigned DIGITS  = 8,
    parameter int unsigned NUM_SRC = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SEL_W   = 3
);
    logic [SEL_W-1:0]          src_sel;
    logic                      hold;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        bcd_mask;
    logic [7:0]                SEG;
    logic [DIGITS-1:0]         AN;
    logic                      busy;
    logic                      ovf;

    modport master (
        output src_sel, hold, src_data, bcd_mask,
        input  SEG, AN, busy, ovf
    );

    modport slave (
        input  src_sel, hold, src_data, bcd_mask,
        output SEG, AN, busy, ovf
    );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment controller: frame-synchronous capture, hex or sequential double-dabble decimal.
// Optional macro LEAD_ZERO_BLANK_EN blanks leading zero digits in decimal mode.
module seg_scan_display #(
    parameter int unsigned DIGITS  = 8,
    parameter int unsigned NUM_SRC = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CLK_DIV = 100_000,
    parameter int unsigned SEL_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_display_if.slave bus
);
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t            state_q, state_n;
    logic [PW-1:0]     pre_q;
    logic [IW-1:0]     idx_q;
    logic              upd_q;
    logic              tick;
    logic              frame_end;
    logic [DATA_W-1:0] word_q, word_n;
    logic              mode_q, mode_n;
    logic [BW-1:0]     bcd_q, bcd_n;
    logic [BW-1:0]     adj;
    logic [CW-1:0]     cnt_q, cnt_n;
    logic              covf_q, covf_n;
    logic [BW-1:0]     disp_q, disp_n;
    logic              ovf_q, ovf_n;
    logic              busy_q;
    logic [7:0]        seg_q;
    logic [DIGITS-1:0] an_q;
    logic [DATA_W-1:0] sel_word;
    logic              sel_mode;
    logic [3:0]        nib;
    logic              blank;
`ifdef LEAD_ZERO_BLANK_EN
    logic              dmode_q, dmode_n;
`endif

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'h0:    return 8'hC0;
            4'h1:    return 8'hF9;
            4'h2:    return 8'hA4;
            4'h3:    return 8'hB0;
            4'h4:    return 8'h99;
            4'h5:    return 8'h92;
            4'h6:    return 8'h82;
            4'h7:    return 8'hF8;
            4'h8:    return 8'h80;
            4'h9:    return 8'h98;
            4'hA:    return 8'h88;
            4'hB:    return 8'h83;
            4'hC:    return 8'hA7;
            4'hD:    return 8'hA1;
            4'hE:    return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        logic [3:0]    n;
        r = b;
        for (int i = 0; i < int'(DIGITS); i++) begin
            n = b[i*4 +: 4];
            if (n >= 4'd5) r[i*4 +: 4] = n + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] hex_low(input logic [DATA_W-1:0] w);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(BW) && i < int'(DATA_W); i++) r[i] = w[i];
        return r;
    endfunction

    function automatic logic hex_ovf(input logic [DATA_W-1:0] w);
        logic o;
        o = 1'b0;
        for (int i = int'(BW); i < int'(DATA_W); i++) o = o | w[i];
        return o;
    endfunction

    assign tick      = (pre_q == PW'(CLK_DIV - 1));
    assign frame_end = tick && (idx_q == IW'(DIGITS - 1));

    // Prescaler and digit scan counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
            upd_q <= 1'b0;
        end else begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
            upd_q <= tick;
            if (tick) idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // Out-of-range src_sel leaves the defaults: word 0 in hex mode
    always_comb begin
        sel_word = '0;
        sel_mode = 1'b0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (bus.src_sel == SEL_W'(k)) begin
                sel_word = bus.src_data[k*DATA_W +: DATA_W];
                sel_mode = bus.bcd_mask[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        word_n  = word_q;
        mode_n  = mode_q;
        bcd_n   = bcd_q;
        cnt_n   = cnt_q;
        covf_n  = covf_q;
        disp_n  = disp_q;
        ovf_n   = ovf_q;
        adj     = '0;
`ifdef LEAD_ZERO_BLANK_EN
        dmode_n = dmode_q;
`endif
        case (state_q)
            IDLE: begin
                if (frame_end && !bus.hold) begin
                    word_n  = sel_word;
                    mode_n  = sel_mode;
                    bcd_n   = '0;
                    cnt_n   = '0;
                    covf_n  = 1'b0;
                    state_n = sel_mode ? CONV : LOAD;
                end
            end
            CONV: begin
                adj    = dabble_adjust(bcd_q);
                covf_n = covf_q | adj[BW-1];
                bcd_n  = {adj[BW-2:0], word_q[DATA_W-1]};
                word_n = {word_q[DATA_W-2:0], 1'b0};
                cnt_n  = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_W - 1)) state_n = LOAD;
            end
            LOAD: begin
                if (mode_q) begin
                    disp_n = bcd_q;
                    ovf_n  = covf_q;
                end else begin
                    disp_n = hex_low(word_q);
                    ovf_n  = hex_ovf(word_q);
                end
`ifdef LEAD_ZERO_BLANK_EN
                dmode_n = mode_q;
`endif
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            mode_q  <= 1'b0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            covf_q  <= 1'b0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
            dmode_q <= 1'b0;
`endif
        end else begin
            word_q  <= word_n;
            mode_q  <= mode_n;
            bcd_q   <= bcd_n;
            cnt_q   <= cnt_n;
            covf_q  <= covf_n;
            disp_q  <= disp_n;
            ovf_q   <= ovf_n;
            busy_q  <= (state_n != IDLE);
`ifdef LEAD_ZERO_BLANK_EN
            dmode_q <= dmode_n;
`endif
        end
    end

    // Digit pick uses disp_n so a LOAD on the slot's first cycle shows for the whole slot
    always_comb begin
        nib = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IW'(i)) nib = disp_n[i*4 +: 4];
        end
`ifdef LEAD_ZERO_BLANK_EN
        blank = dmode_n && (idx_q != '0);
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (i >= int'(idx_q) && disp_n[i*4 +: 4] != 4'h0) blank = 1'b0;
        end
`else
        blank = 1'b0;
`endif
    end

    // SEG/AN only change once per digit slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 8'hFF;
            an_q  <= '1;
        end else if (upd_q) begin
            seg_q <= blank ? 8'hFF : seg_decode(nib);
            an_q  <= ~(DIGITS'(1) << idx_q);
        end
    end

    assign bus.SEG  = seg_q;
    assign bus.AN   = an_q;
    assign bus.busy = busy_q;
    assign bus.ovf  = ovf_q;
endmodule
